// File: rtl/mu0x_pkg.sv
// Shared constants for the mu0x accumulator core: opcode encodings,
// control states and ALU modes.
package mu0x_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_LDA = 4'd0;
  localparam logic [OP_W-1:0] OP_STA = 4'd1;
  localparam logic [OP_W-1:0] OP_ADD = 4'd2;
  localparam logic [OP_W-1:0] OP_SUB = 4'd3;
  localparam logic [OP_W-1:0] OP_JMP = 4'd4;
  localparam logic [OP_W-1:0] OP_JGE = 4'd5;
  localparam logic [OP_W-1:0] OP_JNE = 4'd6;
  localparam logic [OP_W-1:0] OP_STP = 4'd7;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    HALT   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ALU_PASS = 2'd0,
    ALU_ADD  = 2'd1,
    ALU_SUB  = 2'd2
  } alu_mode_t;

endpackage

// File: rtl/mu0x_alu.sv
// Combinational accumulator datapath: pass-through of the memory operand,
// or modulo-2^DATA_W add/subtract against ACC.
module mu0x_alu
  import mu0x_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  alu_mode_t         mode,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

  always_comb begin
    y = b;
    unique case (mode)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      default: y = b;
    endcase
  end

endmodule

// File: rtl/mu0x_core.sv
// MU0-style accumulator core with a req/ack memory port, wait-state tolerant
// FETCH/EXEC phases and a resumable HALT.
//
// state  | meaning
// FETCH  | read instruction at PC, wait for ack
// DECODE | branch resolution, no bus activity
// EXEC   | operand read or ACC write at S, wait for ack
// HALT   | idle until resume
module mu0x_core
  import mu0x_pkg::*;
#(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = DATA_W - 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              sysclk,
  input  logic              ext_reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  input  logic              resume,
  output logic              halted,
  output logic [ADDR_W-1:0] pc_out,
  output logic [DATA_W-1:0] acc_out
);

  if (DATA_W < 8) begin : g_chk_data
    $error("mu0x_core: DATA_W must be at least 8");
  end
  if (ADDR_W > DATA_W - 4) begin : g_chk_addr
    $error("mu0x_core: ADDR_W must not exceed DATA_W-4");
  end

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] ir;
  logic [OP_W-1:0]   opcode;
  logic [ADDR_W-1:0] s_field;
  alu_mode_t         alu_mode;
  logic [DATA_W-1:0] alu_y;

  assign opcode  = ir[DATA_W-1 -: OP_W];
  assign s_field = ir[ADDR_W-1:0];

  always_comb begin
    alu_mode = ALU_PASS;
    if (opcode == OP_ADD) alu_mode = ALU_ADD;
    else if (opcode == OP_SUB) alu_mode = ALU_SUB;
  end

  mu0x_alu #(.DATA_W(DATA_W)) u_alu (
    .mode (alu_mode),
    .a    (acc),
    .b    (mem_rdata),
    .y    (alu_y)
  );

  // Bus outputs come from state and IR only; reset masks req so a pending
  // request is dropped in the reset cycle itself.
  assign mem_req   = !ext_reset && (state == FETCH || state == EXEC);
  assign mem_we    = (state == EXEC) && (opcode == OP_STA);
  assign mem_addr  = (state == EXEC) ? s_field : pc;
  assign mem_wdata = acc;
  assign halted    = !ext_reset && (state == HALT);
  assign pc_out    = pc;
  assign acc_out   = acc;

  always_ff @(posedge sysclk) begin
    if (ext_reset) begin
      state <= FETCH;
      pc    <= RESET_PC;
      acc   <= '0;
      ir    <= '0;
    end else begin
      unique case (state)
        FETCH: begin
          if (mem_ack) begin
            ir    <= mem_rdata;
            pc    <= pc + 1'b1;
            state <= DECODE;
          end
        end
        DECODE: begin
          state <= FETCH;
          unique case (opcode)
            OP_LDA, OP_STA, OP_ADD, OP_SUB: state <= EXEC;
            OP_JMP: pc <= s_field;
            OP_JGE: if (!acc[DATA_W-1]) pc <= s_field;
            OP_JNE: if (acc != '0) pc <= s_field;
            OP_STP: state <= HALT;
            default: ;
          endcase
        end
        EXEC: begin
          if (mem_ack) begin
            if (opcode != OP_STA) acc <= alu_y;
            state <= FETCH;
          end
        end
        HALT: begin
          if (resume) state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mu0x_core.sv
// Self-checking bench for mu0x_core: table of small programs run against a
// wait-state memory model, plus hand sequences for reset, halt and wrap cases.
module tb_mu0x_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        resume = 1'b0;
  logic        mem_req, mem_we, mem_ack, halted;
  logic [11:0] mem_addr, pc_out;
  logic [15:0] mem_wdata, mem_rdata, acc_out;

  logic        rst_w = 1'b1;
  logic        req_w, we_w, ack_w, halted_w;
  logic [19:0] addr_w, pc_w;
  logic [23:0] wdata_w, rdata_w, acc_w;

  always #5 clk = ~clk;

  mu0x_core u_dut (
    .sysclk(clk), .ext_reset(rst), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .resume(resume), .halted(halted),
    .pc_out(pc_out), .acc_out(acc_out)
  );

  mu0x_core #(.DATA_W(24), .ADDR_W(20)) u_wide (
    .sysclk(clk), .ext_reset(rst_w), .mem_req(req_w), .mem_we(we_w),
    .mem_addr(addr_w), .mem_wdata(wdata_w), .mem_rdata(rdata_w),
    .mem_ack(ack_w), .resume(1'b0), .halted(halted_w),
    .pc_out(pc_w), .acc_out(acc_w)
  );

  // ---------------- memory models ----------------
  logic [15:0] mem16 [0:4095];
  logic [23:0] mem24 [0:255];
  int wait_cfg = 0;
  int wcnt = 0;
  int acks = 0, wr_cnt = 0, stab_err = 0;
  logic [11:0] wr_addr;
  logic [15:0] wr_data;
  int wr_cnt_w = 0;
  logic [19:0] wr_addr_w;
  logic [23:0] wr_data_w;

  assign mem_ack   = mem_req && (wcnt >= wait_cfg);
  assign mem_rdata = mem16[mem_addr];
  assign ack_w     = req_w;
  assign rdata_w   = mem24[addr_w[7:0]];

  logic        pend = 1'b0;
  logic [11:0] s_addr;
  logic        s_we;
  logic [15:0] s_wdata;

  always @(posedge clk) begin
    if (mem_req && !mem_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (mem_req && mem_ack) begin
      acks <= acks + 1;
      if (mem_we) begin
        mem16[mem_addr] <= mem_wdata;
        wr_cnt  <= wr_cnt + 1;
        wr_addr <= mem_addr;
        wr_data <= mem_wdata;
      end
    end
    pend    <= !rst && mem_req && !mem_ack;
    s_addr  <= mem_addr;
    s_we    <= mem_we;
    s_wdata <= mem_wdata;
    if (req_w && ack_w && we_w) begin
      mem24[addr_w[7:0]] <= wdata_w;
      wr_cnt_w  <= wr_cnt_w + 1;
      wr_addr_w <= addr_w;
      wr_data_w <= wdata_w;
    end
  end

  // Request fields must hold steady across every wait cycle.
  always @(negedge clk) begin
    if (pend && (mem_addr !== s_addr || mem_we !== s_we || (s_we && mem_wdata !== s_wdata)))
      stab_err <= stab_err + 1;
  end

  // ---------------- checking ----------------
  int tests = 0, failed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) mem16[i] = 16'h7000;
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    acks = 0; wr_cnt = 0; stab_err = 0;
    rst = 1'b0;
    #1;
  endtask

  task automatic run_to_halt(input int budget, output int cyc);
    cyc = 0;
    while (!halted && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  typedef struct {
    string       name;
    logic [15:0] p0, p1, p2, d10, d11;
    int          wt;
    logic [15:0] exp_acc;
    logic [11:0] exp_pc;
    int          exp_cyc, exp_acks, exp_wr;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int cyc;

    vecs[0] = '{"basic",     16'h0010, 16'h2011, 16'h1012, 16'h0005, 16'h0003, 0, 16'h0008, 12'h004, 11, 7, 1};
    vecs[1] = '{"basic_w3",  16'h0010, 16'h2011, 16'h1012, 16'h0005, 16'h0003, 3, 16'h0008, 12'h004, 32, 7, 1};
    vecs[2] = '{"jge_fall",  16'h0010, 16'h5020, 16'h7000, 16'h8000, 16'h0000, 0, 16'h8000, 12'h003, 7, 4, 0};
    vecs[3] = '{"jne_take",  16'h0010, 16'h6030, 16'h7000, 16'h8000, 16'h0000, 0, 16'h8000, 12'h031, 7, 4, 0};
    vecs[4] = '{"jne_fall",  16'h0010, 16'h6030, 16'h7000, 16'h0000, 16'h0000, 0, 16'h0000, 12'h003, 7, 4, 0};
    vecs[5] = '{"jge_take",  16'h0010, 16'h5020, 16'h7000, 16'h0000, 16'h0000, 0, 16'h0000, 12'h021, 7, 4, 0};
    vecs[6] = '{"sub_wrap",  16'h0010, 16'h3011, 16'h7000, 16'h0000, 16'h0001, 0, 16'hFFFF, 12'h003, 8, 5, 0};
    vecs[7] = '{"jmp_w2",    16'h4040, 16'h7000, 16'h7000, 16'h0000, 16'h0000, 2, 16'h0000, 12'h041, 8, 2, 0};
    vecs[8] = '{"nop",       16'h8000, 16'hF123, 16'h7000, 16'h0000, 16'h0000, 0, 16'h0000, 12'h003, 6, 3, 0};
    vecs[9] = '{"add_wrap",  16'h0010, 16'h2011, 16'h7000, 16'hFFFF, 16'h0002, 1, 16'h0001, 12'h003, 8+5, 5, 0};

    // Reset behaviour and first fetch
    clear_mem();
    mem16[0] = 16'h0010; mem16[1] = 16'h2011; mem16[2] = 16'h1012; mem16[3] = 16'h7000;
    mem16[16'h10] = 16'h0005; mem16[16'h11] = 16'h0003;
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    chk("rst_req", mem_req, 0);
    chk("rst_halted", halted, 0);
    chk("rst_pc", pc_out, 0);
    chk("rst_acc", acc_out, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("first_req", mem_req, 1);
    chk("first_addr", mem_addr, 0);
    chk("first_we", mem_we, 0);

    // Table of programs
    for (int v = 0; v < 10; v++) begin
      clear_mem();
      mem16[0] = vecs[v].p0; mem16[1] = vecs[v].p1; mem16[2] = vecs[v].p2;
      mem16[16'h10] = vecs[v].d10; mem16[16'h11] = vecs[v].d11;
      wait_cfg = vecs[v].wt;
      do_reset();
      run_to_halt(500, cyc);
      chk({vecs[v].name, "_cycles"}, cyc, vecs[v].exp_cyc);
      chk({vecs[v].name, "_halted"}, halted, 1);
      chk({vecs[v].name, "_acc"}, acc_out, vecs[v].exp_acc);
      chk({vecs[v].name, "_pc"}, pc_out, vecs[v].exp_pc);
      chk({vecs[v].name, "_acks"}, acks, vecs[v].exp_acks);
      chk({vecs[v].name, "_writes"}, wr_cnt, vecs[v].exp_wr);
      chk({vecs[v].name, "_stable"}, stab_err, 0);
      if (vecs[v].exp_wr > 0) begin
        chk({vecs[v].name, "_wr_addr"}, wr_addr, 12'h012);
        chk({vecs[v].name, "_wr_data"}, wr_data, vecs[v].exp_acc);
        chk({vecs[v].name, "_mem12"}, mem16[12'h012], vecs[v].exp_acc);
      end
    end
    wait_cfg = 0;

    // Halt, idle with resume low, then resume at STP+1
    clear_mem();
    mem16[0] = 16'h7000; mem16[1] = 16'h0010; mem16[16'h10] = 16'h1234;
    do_reset();
    run_to_halt(50, cyc);
    chk("stp_cycles", cyc, 2);
    begin
      int reqs = 0;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        if (mem_req) reqs++;
      end
      chk("halt_idle_reqs", reqs, 0);
    end
    chk("halt_held", halted, 1);
    resume = 1'b1;
    @(negedge clk) resume = 1'b0;
    #1;
    chk("resume_req", mem_req, 1);
    chk("resume_addr", mem_addr, 12'h001);
    chk("resume_halted", halted, 0);
    run_to_halt(50, cyc);
    chk("resume_acc", acc_out, 16'h1234);
    chk("resume_pc", pc_out, 12'h003);

    // resume already high on HALT entry: exactly one cycle in HALT
    clear_mem();
    mem16[0] = 16'h7000;
    resume = 1'b1;
    do_reset();
    @(negedge clk); @(negedge clk);
    chk("rh_halted", halted, 1);
    @(negedge clk);
    chk("rh_left", halted, 0);
    chk("rh_addr", {mem_req, mem_addr}, {1'b1, 12'h001});
    resume = 1'b0;

    // JMP to top of address space, NOP there, PC wraps to 0
    clear_mem();
    mem16[0] = 16'h4FFF; mem16[12'hFFF] = 16'h8000;
    do_reset();
    @(negedge clk); @(negedge clk);
    chk("jmp_top_addr", mem_addr, 12'hFFF);
    @(negedge clk); @(negedge clk);
    chk("wrap_pc", pc_out, 12'h000);
    chk("wrap_fetch", {mem_req, mem_addr}, {1'b1, 12'h000});

    // Reset during an EXEC wait cycle of a STA
    clear_mem();
    mem16[0] = 16'h0010; mem16[1] = 16'h1012;
    mem16[16'h10] = 16'h00AA; mem16[16'h12] = 16'h5555;
    wait_cfg = 3;
    do_reset();
    begin
      int n = 0;
      while (!(mem_req && mem_we) && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("sta_exec_reached", (mem_req && mem_we), 1);
    end
    @(negedge clk) rst = 1'b1;
    #1;
    chk("midrst_req", mem_req, 0);
    @(negedge clk);
    chk("midrst_writes", wr_cnt, 0);
    chk("midrst_mem", mem16[12'h012], 16'h5555);
    rst = 1'b0;
    #1;
    chk("midrst_restart", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 12'h000});
    chk("midrst_acc", acc_out, 0);
    run_to_halt(200, cyc);
    chk("midrst_rerun_mem", mem16[12'h012], 16'h00AA);
    wait_cfg = 0;

    // 24-bit data / 20-bit address variant, basic program
    for (int i = 0; i < 256; i++) mem24[i] = 24'h700000;
    mem24[0] = 24'h000010; mem24[1] = 24'h200011; mem24[2] = 24'h100012; mem24[3] = 24'h700000;
    mem24[8'h10] = 24'h000005; mem24[8'h11] = 24'h000003;
    @(negedge clk) rst_w = 1'b1;
    @(negedge clk);
    @(negedge clk);
    wr_cnt_w = 0;
    rst_w = 1'b0;
    #1;
    begin
      int c = 0;
      while (!halted_w && c < 500) begin
        @(negedge clk);
        c++;
      end
      chk("wide_cycles", c, 11);
    end
    chk("wide_acc", acc_w, 24'h000008);
    chk("wide_pc", pc_w, 20'h00004);
    chk("wide_writes", wr_cnt_w, 1);
    chk("wide_wr", {wr_addr_w, wr_data_w}, {20'h00012, 24'h000008});

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
